// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
//   KeyScanState : scanner FSM state encoding
//   KEYPAD_ROWS / KEYPAD_COLS : matrix dimensions
//   key_code()   : maps a (row, column) position to its 4-bit key code
package keypad_pkg;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } KeyScanState;

  localparam int KEYPAD_ROWS = 4;
  localparam int KEYPAD_COLS = 4;

  // Code = 4*row + col, which for a 4x4 matrix is just {row, col}.
  function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
//   clk        : system clock
//   rst        : synchronous active-high reset, loads all-ones (idle rows)
//   async_bits : raw asynchronous inputs
//   sync_bits  : inputs re-timed to clk, two cycles of latency
module row_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_bits,
  output logic [WIDTH-1:0] sync_bits
);

  logic [WIDTH-1:0] meta;

  // Reset to all-ones so a held key is not seen until it is re-sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta      <= '1;
      sync_bits <= '1;
    end else begin
      meta      <= async_bits;
      sync_bits <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
//   CLK      : system clock
//   RST      : synchronous active-high reset
//   rows     : row lines from the keypad, active-low, asynchronous
//   cols     : column drive, active-low one-hot
//   digit    : code of the last accepted key (4*row + col), held between presses
//   keyValid : one-cycle strobe when a debounced press is accepted
//   keyHeld  : high while the accepted key is still down (pressed or releasing)
//   multiKey : one-cycle flag when a scan sample shows two or more rows low
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [KEYPAD_ROWS-1:0] rows,
  output logic [KEYPAD_COLS-1:0] cols,
  output logic [3:0]             digit,
  output logic                   keyValid,
  output logic                   keyHeld,
  output logic                   multiKey
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

  KeyScanState      state, state_nxt;
  logic [1:0]       col, col_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [DB_W-1:0]  db, db_nxt;
  logic [3:0]       digit_nxt;
  logic             key_valid_nxt;
  logic             latch;
  logic             multi;

  logic [3:0]       rows_s;
  logic [3:0]       low;
  logic             low_any;
  logic             low_multi;
  logic [3:0]       cand_rows;
  logic [3:0]       cand_code;

  // Lowest-numbered low row; only used when exactly one row is low.
  function automatic logic [1:0] row_index(input logic [3:0] lows);
    if (lows[0]) return 2'd0;
    if (lows[1]) return 2'd1;
    if (lows[2]) return 2'd2;
    return 2'd3;
  endfunction

  row_synchronizer #(
    .WIDTH(KEYPAD_ROWS)
  ) u_sync (
    .clk       (CLK),
    .rst       (RST),
    .async_bits(rows),
    .sync_bits (rows_s)
  );

  assign low       = ~rows_s;
  assign low_any   = |low;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign low_multi = |(low & (low - 4'd1));

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    div_nxt       = div;
    db_nxt        = db;
    digit_nxt     = digit;
    key_valid_nxt = 1'b0;
    latch         = 1'b0;
    multi         = 1'b0;
    case (state)
      S_SCAN: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (low_any && !low_multi) begin
            // Single key seen: freeze this column and start debouncing it.
            state_nxt = S_DEBOUNCE;
            db_nxt    = '0;
            latch     = 1'b1;
          end else begin
            col_nxt = col + 2'd1;
            multi   = low_multi;
          end
        end else begin
          div_nxt = div + DIV_ONE;
        end
      end
      S_DEBOUNCE: begin
        if (rows_s == cand_rows) begin
          if (db == DB_LAST) begin
            state_nxt     = S_PRESSED;
            digit_nxt     = cand_code;
            key_valid_nxt = 1'b1;
          end else begin
            db_nxt = db + DB_ONE;
          end
        end else begin
          state_nxt = S_SCAN;
          db_nxt    = '0;
          div_nxt   = '0;
          col_nxt   = col + 2'd1;
        end
      end
      S_PRESSED: begin
        // Additional rows going low are deliberately ignored while held.
        if (rows_s == 4'hF) begin
          state_nxt = S_RELEASE;
          db_nxt    = '0;
        end
      end
      S_RELEASE: begin
        if (rows_s == 4'hF) begin
          if (db == DB_LAST) begin
            state_nxt = S_SCAN;
            db_nxt    = '0;
            div_nxt   = '0;
            col_nxt   = col + 2'd1;
          end else begin
            db_nxt = db + DB_ONE;
          end
        end else begin
          state_nxt = S_PRESSED;
        end
      end
      default: begin
        state_nxt = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_SCAN;
      col      <= 2'd0;
      div      <= '0;
      db       <= '0;
      digit    <= 4'd0;
      keyValid <= 1'b0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      div      <= div_nxt;
      db       <= db_nxt;
      digit    <= digit_nxt;
      keyValid <= key_valid_nxt;
    end
  end

  // Candidate pattern and code; always loaded before they are consulted.
  always_ff @(posedge CLK) begin
    if (latch) begin
      cand_rows <= rows_s;
      cand_code <= key_code(row_index(low), col);
    end
  end

  assign cols     = ~(4'b0001 << col);
  assign keyHeld  = (state == S_PRESSED) || (state == S_RELEASE);
  assign multiKey = multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with SCAN_DIV=4 and
// DEBOUNCE_CYCLES=8. A key matrix model pulls a row low whenever a pressed
// key's column is driven. Cycle numbers count negedges after a reset edge.
module tb_keypad_scanner;

  logic        CLK;
  logic        RST;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  digit;
  logic        keyValid;
  logic        keyHeld;
  logic        multiKey;

  logic [15:0] keys;
  int          cyc;
  int          kv_cnt;
  int          kv_first;
  int          mk_cnt;
  int          errors;
  int          checks;
  logic [3:0]  exp_cols;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .rows    (rows),
    .cols    (cols),
    .digit   (digit),
    .keyValid(keyValid),
    .keyHeld (keyHeld),
    .multiKey(multiKey)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    if (keyValid) begin
      kv_cnt++;
      if (kv_first < 0) kv_first = cyc;
    end
    if (multiKey) mk_cnt++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    cyc      = 0;
    kv_cnt   = 0;
    kv_first = -1;
    mk_cnt   = 0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    keys     = '0;
    RST      = 1'b1;
    cyc      = 0;
    kv_cnt   = 0;
    kv_first = -1;
    mk_cnt   = 0;
    repeat (3) @(negedge CLK);

    // Idle scan: columns rotate every 4 cycles, all outputs quiet.
    apply_reset();
    for (int k = 0; k < 100; k++) begin
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      check("idle", {5'd0, cols, keyValid, keyHeld, multiKey, digit},
            {5'd0, exp_cols, 3'b000, 4'h0});
      step();
    end

    // Single clean press of key 9 (row 2, column 1).
    apply_reset();
    keys[9] = 1'b1;
    run_to(15);
    check("k9_pre", {15'd0, keyValid}, 16'd0);
    run_to(16);
    check("k9_valid", {10'd0, keyValid, keyHeld, digit}, {10'd0, 2'b11, 4'd9});
    run_to(17);
    check("k9_pulse", {15'd0, keyValid}, 16'd0);
    run_to(40);
    keys = '0;
    run_to(50);
    check("k9_held", {15'd0, keyHeld}, 16'd1);
    run_to(51);
    check("k9_release", {11'd0, cols, keyHeld}, {11'd0, 4'b1011, 1'b0});
    check("k9_count", 16'(kv_cnt), 16'd1);

    // Key 3 (row 0, column 3) with two 3-cycle bounces before settling.
    apply_reset();
    keys[3] = 1'b1;
    run_to(18); keys[3] = 1'b0;
    run_to(21); keys[3] = 1'b1;
    run_to(39); keys[3] = 1'b0;
    run_to(42); keys[3] = 1'b1;
    run_to(65);
    check("k3_no_early", 16'(kv_cnt), 16'd0);
    run_to(66);
    check("k3_valid", {11'd0, keyValid, digit}, {11'd0, 1'b1, 4'd3});
    run_to(80);
    check("k3_count", 16'(kv_cnt), 16'd1);

    // Release with a 5-cycle re-press glitch: key stays held, no new strobe.
    keys[3] = 1'b0;
    run_to(85); keys[3] = 1'b1;
    run_to(87);
    check("glitch_held_a", {15'd0, keyHeld}, 16'd1);
    run_to(90); keys[3] = 1'b0;
    check("glitch_held_b", {15'd0, keyHeld}, 16'd1);
    run_to(100);
    check("glitch_held_c", {15'd0, keyHeld}, 16'd1);
    run_to(101);
    check("glitch_drop", {11'd0, cols, keyHeld}, {11'd0, 4'b1110, 1'b0});
    check("glitch_count", {12'd0, 4'(kv_cnt), digit}, {12'd0, 4'd1, 4'd3});

    // Reset in the middle of debouncing key 9 discards the press.
    keys[9] = 1'b1;
    run_to(112);
    check("rst_pre", {14'd0, keyValid, keyHeld}, 16'd0);
    RST = 1'b1;
    run_to(113);
    RST = 1'b0;
    check("rst_state", {5'd0, cols, keyValid, keyHeld, multiKey, digit},
          {5'd0, 4'b1110, 3'b000, 4'h0});
    kv_cnt = 0;
    run_to(128);
    check("rst_no_early", 16'(kv_cnt), 16'd0);
    run_to(129);
    check("rst_revalid", {11'd0, keyValid, digit}, {11'd0, 1'b1, 4'd9});
    keys = '0;
    run_to(150);

    // Rows 1 and 3 low together (keys 6 and 14 share column 2).
    apply_reset();
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    run_to(10);
    check("multi_pre", {15'd0, multiKey}, 16'd0);
    run_to(11);
    check("multi_pulse", {15'd0, multiKey}, 16'd1);
    run_to(12);
    check("multi_after", {11'd0, cols, multiKey}, {11'd0, 4'b0111, 1'b0});
    run_to(31);
    check("multi_count", 16'(mk_cnt), 16'd2);
    run_to(40);
    check("multi_no_valid", {11'd0, 4'(kv_cnt), keyHeld}, 16'd0);
    keys = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces press and release, and emits one 4-bit key code with a single-cycle strobe per physical press. It sits directly upstream of the serial password lock: `digit` feeds the lock's digit input, and `keyValid` is the per-digit advance strobe, used as a clock enable in the top level. All logic runs on the system clock, with one strobe per keystroke regardless of hold time.

## Interface
Parameters:
- SCAN_DIV, 1000: cycles each column is driven before advancing; ≥2.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required for press and for release; ≥2.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- rows  in  4  keypad row lines, active-low (board pull-ups), asynchronous.
- cols  out  4  column drive, active-low one-hot.
- digit  out  4  code of last accepted key = 4*rowIdx + colIdx; holds between presses.
- keyValid  out  1  one-cycle pulse when a debounced press is accepted.
- keyHeld  out  1  high while the accepted key remains pressed (S_PRESSED, S_RELEASE).
- multiKey  out  1  one-cycle pulse when a scan sample shows ≥2 rows low.

## Operation
- rows passes through a 2-flop synchronizer before all use (`rowsS`).
- Free column index `col` (0..3) and dwell counter `div` (0..SCAN_DIV-1); cols = ~(4'b0001 << col).
- States: S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE.
- S_SCAN: `div` counts. On the cycle `div`==SCAN_DIV-1, sample `rowsS`:
  - exactly one bit low: latch candidate row/col, clear debounce counter `db`, go S_DEBOUNCE; column frozen.
  - ≥2 bits low: multiKey=1 for that cycle, col advances, stay.
  - all high: col advances (3 wraps to 0), stay.
- S_DEBOUNCE: each cycle, if `rowsS` equals the candidate pattern, `db`++. Any mismatch returns to S_SCAN: `db`=0, `div`=0, col advances. When `db`==DEBOUNCE_CYCLES-1 and the pattern matches, the next edge loads digit, pulses keyValid, and enters S_PRESSED.
- S_PRESSED: column frozen. When `rowsS`==4'b1111, go S_RELEASE with `db`=0. Extra rows going low are ignored; no multiKey here.
- S_RELEASE: all-high cycles increment `db`; any low bit returns to S_PRESSED. At `db`==DEBOUNCE_CYCLES-1 with all high, go S_SCAN with `div`=0 and col+1.
- Width rules: `db` and `div` are $clog2 of their parameter; codes never exceed 15.
- Reset (RST=1 at an edge), regardless of state:
  - state S_SCAN, col=0 (cols=4'b1110), div=0, db=0.
  - digit=0, keyValid=0, keyHeld=0, multiKey=0, synchronizer flops=4'b1111.
  - A press in progress is discarded; no keyValid for it.

## Timing
- Row input to `rowsS`: 2 cycles.
- keyValid rises exactly DEBOUNCE_CYCLES cycles after entry to S_DEBOUNCE and is high for exactly 1 cycle.
- digit changes only on the edge that raises keyValid, so it is valid in that cycle and stable afterwards.
- keyHeld rises with keyValid. It falls on the edge that leaves S_RELEASE, DEBOUNCE_CYCLES cycles after the last-released sample.
- Worst-case press-detect latency: 2 + 4*SCAN_DIV + DEBOUNCE_CYCLES cycles.
- A bounce shorter than DEBOUNCE_CYCLES produces no strobe. A release glitch shorter than DEBOUNCE_CYCLES produces no second strobe.
- No back-pressure: the downstream stage must consume `digit` in the keyValid cycle.

## Structure
- Shared package `keypad_pkg`:
  - `KeyScanState` enum (logic [1:0]).
  - Constants KEYPAD_ROWS=4 and KEYPAD_COLS=4.
  - Function `key_code(rowIdx, colIdx)`.
- Sub-module `row_synchronizer`: parameterized-width 2-flop synchronizer with a sync active-high reset value of all-ones.
- Top-level glue drives the lock with keyValid as its digit enable.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8.
- Reset then idle 100 cycles -> cols cycles 1110,1101,1011,0111 every 4 cycles; keyValid, keyHeld and multiKey stay 0; digit=0.
- Hold row 2 low only while col 1 is driven, steady 40 cycles -> single keyValid with digit=9, exactly 8 cycles after S_DEBOUNCE entry; keyHeld=1 until 8 cycles after release.
- Press row 0/col 3 with 3-cycle bounces twice before settling -> exactly one keyValid, digit=3.
- Accepted key, then release with a 5-cycle re-press glitch -> no second keyValid; keyHeld stays 1 through the glitch.
- Rows 1 and 3 low simultaneously at a sample point -> multiKey pulses 1 cycle, no keyValid, scanning continues.
- RST asserted for 1 cycle mid-S_DEBOUNCE -> next cycle cols=1110, all outputs 0; key still held yields a fresh keyValid only after a full re-debounce.
